uart_tx_wb: RTL
===============

UART_TX_WB -- requirements
Module: uart_tx_wb

Interface
REQ-001 Parameter: ADDR_BASE, default 0, base byte address of the register window.
REQ-002 Parameter: FIFO_DEPTH, default 16, TX FIFO entries; power of two, 2..256.
REQ-003 Clk  input  1  system clock; all logic on rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  bus request from initiator.
REQ-006 we  input  1  1 = write, 0 = read; valid with req.
REQ-007 addr  input  32  word address, bits [1:0] always 0.
REQ-008 be  input  4  byte enable; exactly one bit set (byte access).
REQ-009 wdata  input  32  write data, byte replicated on all lanes.
REQ-010 gnt  output  1  request accepted, one-cycle pulse.
REQ-011 rvalid  output  1  read data valid, one-cycle pulse.
REQ-012 rdata  output  32  read data; selected byte on its lane, other lanes 0.
REQ-013 TX  output  1  serial line, idle high.
REQ-014 Int  output  1  level interrupt.

Function
REQ-015 Register map (byte offset from ADDR_BASE): 0x0 DATA (W: push FIFO), 0x1 CR (RW), 0x2 DLL (RW), 0x3 DLH (RW), 0x4 SR (R), 0x5 TXCNT (R, FIFO occupancy).
REQ-016 CR bits: [0] parity enable, [1] 1=even/0=odd, [4] TX-empty interrupt enable; other bits read 0.
REQ-017 SR bits: [0] FIFO full, [1] FIFO empty, [2] serializer busy, [3] overflow (sticky); other bits 0.
REQ-018 Handshake: req sampled high in cycle N (gnt low) -> gnt=1 in cycle N+1 only; the write takes effect at the end of cycle N+1.
REQ-019 Read: rvalid=1 and rdata valid in cycle N+2 for one cycle; rdata returns 0 in all other cycles.
REQ-020 While gnt=1 a held req is not re-accepted; minimum 3 cycles between accepted reads, 2 between writes.
REQ-021 Addresses outside window or unmapped offsets: still granted; writes ignored, reads return 0.
REQ-022 Write to DATA when FIFO full: byte dropped, SR[3] set; SR[3] cleared by a read of SR (cleared in the rvalid cycle).
REQ-023 Bit period = {DLH,DLL}+1 Clk cycles; divisor 0 gives 1 cycle per bit.
REQ-024 Divisor and CR are latched at frame start; changes mid-frame apply to the next frame.
REQ-025 Serializer FSM: IDLE -> START (TX=0) -> DATA (8 bits, LSB first) -> PARITY (only if CR[0]) -> STOP (TX=1) -> IDLE; each non-IDLE state is held for one bit period per bit.
REQ-026 IDLE with FIFO non-empty: pop in that cycle, enter START next cycle; STOP exit with FIFO non-empty goes directly to START (no idle bit).
REQ-027 Parity: odd -> total ones over data+parity odd; even -> even.
REQ-028 Simultaneous push and pop: both performed, occupancy unchanged; a push into an empty FIFO is not visible to the pop until the next cycle.
REQ-029 Pointers wrap modulo FIFO_DEPTH; occupancy counter ranges 0..FIFO_DEPTH.
REQ-030 Int = CR[4] and FIFO empty and serializer in IDLE, registered (one-cycle delay).

Reset
REQ-031 Rst=1 at a clock edge: TX=1, gnt=0, rvalid=0, rdata=0, Int=0, CR=DLL=DLH=0, FIFO empty, SR[3]=0, FSM=IDLE.
REQ-032 Rst mid-frame: frame aborted, TX=1 in the next cycle; no pending bus response is issued.

Verification
REQ-033 DLL=3, CR=0, write DATA 0x55 -> TX: start 0, bits 1,0,1,0,1,0,1,0, stop 1, each held 4 cycles, 40 cycles total.
REQ-034 CR=0x01 (odd), write 0x07 -> parity bit 0; CR=0x03 (even), write 0x07 -> parity bit 1.
REQ-035 Write FIFO_DEPTH+2 bytes with the divisor at max -> TXCNT reads 16 (FIFO_DEPTH, minus any already popped); SR[3]=1; second SR read shows SR[3]=0.
REQ-036 Read CR after writing 0x13 -> gnt in cycle N+1, rvalid in N+2, rdata[15:8]=0x13, other lanes 0.
REQ-037 CR[4]=1, send 2 bytes back-to-back -> no idle gap between frames; Int rises 1 cycle after second stop bit ends.
REQ-038 Assert Rst during DATA state -> TX=1 next cycle, TXCNT=0, Int=0.

Source files
------------

// File: rtl/uart_tx_wb.sv
// Byte-wide register-mapped UART transmitter: bus slave with TX FIFO and a
// programmable-divisor serializer (start, 8 data LSB first, optional parity, stop).
module uart_tx_wb #(
    parameter logic [31:0] ADDR_BASE  = 32'h0,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        TX,
    output logic        Int
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic          gnt_reg, rvalid_reg, we_reg;
    logic [31:0]   addr_reg, wdata_reg, rdata_reg;
    logic [3:0]    be_reg;
    logic [7:0]    cr_reg, dll_reg, dlh_reg;
    logic          ovf_reg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [8:0]    count_reg;

    state_t        state_reg;
    logic [15:0]   div_reg, baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          par_en_reg, par_even_reg, tx_reg, int_reg;

    logic [31:0]   rel;
    logic [1:0]    lane;
    logic          lane_ok, hit, accept, wr_stb, rd_stb;
    logic [2:0]    offset;
    logic [7:0]    wbyte, rbyte;
    logic          full, empty, busy, baud_done, push, pop;

    assign full      = (count_reg == 9'(FIFO_DEPTH));
    assign empty     = (count_reg == 9'd0);
    assign busy      = (state_reg != S_IDLE);
    assign baud_done = (baud_cnt_reg == div_reg);
    assign accept    = req && !gnt_reg && !rvalid_reg;
    assign wr_stb    = gnt_reg && we_reg && hit;
    assign rd_stb    = gnt_reg && !we_reg;
    assign push      = wr_stb && (offset == 3'd0) && !full;
    // The serializer pops when idle, or when finishing a stop bit so frames run back-to-back.
    assign pop       = !empty && ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_done));

    always_comb begin
        rel     = addr_reg - ADDR_BASE;
        lane    = 2'd0;
        lane_ok = 1'b1;
        case (be_reg)
            4'b0001: lane = 2'd0;
            4'b0010: lane = 2'd1;
            4'b0100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: lane_ok = 1'b0;
        endcase
        offset = {rel[2], lane};
        hit    = lane_ok && (rel[31:3] == 29'd0) && (rel[1:0] == 2'b00) && (offset <= 3'd5);
        wbyte  = wdata_reg[8*lane +: 8];
        rbyte  = 8'h00;
        if (hit) begin
            case (offset)
                3'd1:    rbyte = cr_reg;
                3'd2:    rbyte = dll_reg;
                3'd3:    rbyte = dlh_reg;
                3'd4:    rbyte = {4'b0000, ovf_reg, busy, empty, full};
                3'd5:    rbyte = count_reg[7:0];
                default: rbyte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            gnt_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'h0;
            we_reg     <= 1'b0;
            addr_reg   <= 32'h0;
            be_reg     <= 4'h0;
            wdata_reg  <= 32'h0;
            cr_reg     <= 8'h00;
            dll_reg    <= 8'h00;
            dlh_reg    <= 8'h00;
            ovf_reg    <= 1'b0;
        end else begin
            gnt_reg    <= accept;
            rvalid_reg <= rd_stb;
            rdata_reg  <= rd_stb ? ({24'h0, rbyte} << (8*lane)) : 32'h0;
            if (accept) begin
                we_reg    <= we;
                addr_reg  <= addr;
                be_reg    <= be;
                wdata_reg <= wdata;
            end
            if (wr_stb) begin
                case (offset)
                    3'd1:    cr_reg  <= wbyte & 8'h13;
                    3'd2:    dll_reg <= wbyte;
                    3'd3:    dlh_reg <= wbyte;
                    default: ;
                endcase
            end
            // rdata captures SR with the old sticky bit in the same edge that clears it.
            if (wr_stb && (offset == 3'd0) && full)
                ovf_reg <= 1'b1;
            else if (rd_stb && hit && (offset == 3'd4))
                ovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr_reg] <= wbyte;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 9'd0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 9'd1;
                2'b01:   count_reg <= count_reg - 9'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg    <= S_IDLE;
            tx_reg       <= 1'b1;
            int_reg      <= 1'b0;
            div_reg      <= 16'h0;
            baud_cnt_reg <= 16'h0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            par_en_reg   <= 1'b0;
            par_even_reg <= 1'b0;
        end else begin
            int_reg <= cr_reg[4] && empty && (state_reg == S_IDLE);
            if (pop) begin
                // Frame format and divisor are frozen here for the whole frame.
                shift_reg    <= mem[rd_ptr_reg];
                div_reg      <= {dlh_reg, dll_reg};
                par_en_reg   <= cr_reg[0];
                par_even_reg <= cr_reg[1];
                baud_cnt_reg <= 16'h0;
                tx_reg       <= 1'b0;
                state_reg    <= S_START;
            end else if (state_reg != S_IDLE) begin
                if (!baud_done) begin
                    baud_cnt_reg <= baud_cnt_reg + 16'd1;
                end else begin
                    baud_cnt_reg <= 16'h0;
                    case (state_reg)
                        S_START: begin
                            bit_idx_reg <= 3'd0;
                            tx_reg      <= shift_reg[0];
                            state_reg   <= S_DATA;
                        end
                        S_DATA: begin
                            if (bit_idx_reg != 3'd7) begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                                tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                            end else if (par_en_reg) begin
                                tx_reg    <= par_even_reg ? ^shift_reg : ~^shift_reg;
                                state_reg <= S_PARITY;
                            end else begin
                                tx_reg    <= 1'b1;
                                state_reg <= S_STOP;
                            end
                        end
                        S_PARITY: begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_STOP;
                        end
                        default: begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign gnt    = gnt_reg;
    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;
    assign TX     = tx_reg;
    assign Int    = int_reg;
endmodule
